// File: rtl/fc_layer_sequencer.sv
// Drives a single time-multiplexed MAC core through a fully-connected layer.
// The core shares rst with this block, so it is held in reset whenever rst=1.
module fc_layer_sequencer #(
  parameter int N         = 16,
  parameter int ACC_WIDTH = 40,
  parameter int MAX_IN    = 64,
  parameter int MAX_OUT   = 32,
  parameter int IW        = $clog2(MAX_IN + 1),
  parameter int OW        = $clog2(MAX_OUT + 1),
  parameter int WAW       = $clog2(MAX_IN * MAX_OUT)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [IW-1:0]              cfg_n_in,
  input  logic [OW-1:0]              cfg_n_out,
  input  logic [1:0]                 cfg_act_sel,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [$clog2(MAX_IN)-1:0]  x_addr,
  output logic [WAW-1:0]             w_addr,
  output logic [$clog2(MAX_OUT)-1:0] b_addr,
  output logic                       mem_re,
  output logic                       core_start,
  output logic                       core_xw_val,
  output logic                       core_xw_last,
  output logic [1:0]                 core_act_sel,
  input  logic                       core_done,
  input  logic [N-1:0]               core_out,
  output logic                       y_we,
  output logic [$clog2(MAX_OUT)-1:0] y_addr,
  output logic [N-1:0]               y_wdata
);

  localparam int XAW = $clog2(MAX_IN);
  localparam int YAW = $clog2(MAX_OUT);
  localparam logic [IW-1:0] MAX_IN_C  = IW'(MAX_IN);
  localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUT);

  // The core accumulator must hold at least one full-width product.
  if (ACC_WIDTH < 2 * N) begin : g_acc_chk
    $error("ACC_WIDTH narrower than one product");
  end

  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, FIN} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   n_in_q;
  logic [OW-1:0]   n_out_q;
  logic [1:0]      act_q;
  logic [XAW-1:0]  i_q;
  logic [YAW-1:0]  j_q;
  logic [WAW-1:0]  wp_q;
  logic            last_i, last_j, cfg_bad;

  assign last_i  = (IW'(i_q) == n_in_q - IW'(1));
  assign last_j  = (OW'(j_q) == n_out_q - OW'(1));
  assign cfg_bad = (n_in_q == '0) || (n_in_q > MAX_IN_C) ||
                   (n_out_q == '0) || (n_out_q > MAX_OUT_C);
  assign core_act_sel = act_q;

  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    done    = 1'b0;
    err     = 1'b0;
    mem_re  = 1'b0;
    x_addr  = '0;
    w_addr  = '0;
    b_addr  = '0;
    y_we    = 1'b0;
    y_addr  = '0;
    y_wdata = '0;
    case (state_q)
      IDLE:  if (start) state_d = CHECK;
      CHECK: state_d = cfg_bad ? FIN : ISSUE;
      ISSUE: begin
        mem_re = 1'b1;
        x_addr = i_q;
        w_addr = wp_q;
        b_addr = j_q;
        if (last_i) state_d = WAIT;
      end
      WAIT: if (core_done) begin
        y_we    = 1'b1;
        y_addr  = j_q;
        y_wdata = core_out;
        state_d = last_j ? FIN : ISSUE;
      end
      FIN: begin
        done    = 1'b1;
        err     = cfg_bad;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort kills every side effect of the current cycle, including a late core_done.
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      mem_re  = 1'b0;
      y_we    = 1'b0;
      done    = 1'b0;
      err     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      n_in_q       <= '0;
      n_out_q      <= '0;
      act_q        <= '0;
      i_q          <= '0;
      j_q          <= '0;
      wp_q         <= '0;
      core_start   <= 1'b0;
      core_xw_val  <= 1'b0;
      core_xw_last <= 1'b0;
    end else begin
      state_q      <= state_d;
      // Core controls trail the read issue by one cycle to line up with read data.
      core_xw_val  <= mem_re;
      core_start   <= mem_re && (i_q == '0);
      core_xw_last <= mem_re && last_i;
      case (state_q)
        IDLE: if (start) begin
          n_in_q  <= cfg_n_in;
          n_out_q <= cfg_n_out;
          act_q   <= cfg_act_sel;
        end
        CHECK: begin
          i_q  <= '0;
          j_q  <= '0;
          wp_q <= '0;
        end
        ISSUE: begin
          i_q  <= i_q + 1'b1;
          wp_q <= wp_q + 1'b1;
        end
        WAIT: if (core_done && !last_j) begin
          j_q <= j_q + 1'b1;
          i_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Bench for fc_layer_sequencer: memories and a MAC core stub around the DUT,
// results compared against a direct dot-product reference of the layer.
module tb_fc_layer_sequencer;
  localparam int N = 16, MAX_IN = 64, MAX_OUT = 32;
  localparam int IW = 7, OW = 6, WAW = 11, XAW = 6, YAW = 5;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [IW-1:0] cfg_n_in = '0;
  logic [OW-1:0] cfg_n_out = '0;
  logic [1:0] cfg_act_sel = '0;
  logic busy, done, err, mem_re, core_start, core_xw_val, core_xw_last, y_we;
  logic [XAW-1:0] x_addr;
  logic [WAW-1:0] w_addr;
  logic [YAW-1:0] b_addr, y_addr;
  logic [1:0] core_act_sel;
  logic core_done;
  logic [N-1:0] core_out, y_wdata;

  fc_layer_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_n_in(cfg_n_in), .cfg_n_out(cfg_n_out), .cfg_act_sel(cfg_act_sel),
    .busy(busy), .done(done), .err(err),
    .x_addr(x_addr), .w_addr(w_addr), .b_addr(b_addr), .mem_re(mem_re),
    .core_start(core_start), .core_xw_val(core_xw_val), .core_xw_last(core_xw_last),
    .core_act_sel(core_act_sel), .core_done(core_done), .core_out(core_out),
    .y_we(y_we), .y_addr(y_addr), .y_wdata(y_wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memories with one-cycle read latency
  logic [15:0] x_mem [MAX_IN];
  logic [15:0] w_mem [MAX_IN*MAX_OUT];
  logic [15:0] b_mem [MAX_OUT];
  logic signed [15:0] x_rd, w_rd, b_rd;
  always @(posedge clk) if (mem_re) begin
    x_rd <= x_mem[x_addr];
    w_rd <= w_mem[w_addr];
    b_rd <= b_mem[b_addr];
  end

  // MAC core stub: bias load on start, accumulate each beat, result one cycle after last
  logic signed [39:0] acc_m, nacc;
  logic signed [31:0] prod;
  assign prod = x_rd * w_rd;
  assign nacc = (core_start ? {{24{b_rd[15]}}, b_rd} : acc_m) + {{8{prod[31]}}, prod};
  always @(posedge clk) begin
    if (rst) begin
      acc_m <= '0; core_done <= 1'b0; core_out <= '0;
    end else begin
      core_done <= 1'b0;
      if (core_xw_val) begin
        acc_m <= nacc;
        if (core_xw_last) begin
          core_done <= 1'b1;
          core_out  <= (core_act_sel == 2'd1 && nacc < 0) ? 16'h0 : nacc[15:0];
        end
      end
    end
  end

  // Monitor
  int iw_q[$], ix_q[$], ib_q[$], ya_q[$], yd_q[$], yc_q[$];
  int nval, nstart, nboth, ndone, done_cyc, act_bad, exp_act;
  logic done_seen, done_err;
  always @(negedge clk) begin
    if (mem_re) begin iw_q.push_back(int'(w_addr)); ix_q.push_back(int'(x_addr)); ib_q.push_back(int'(b_addr)); end
    if (y_we) begin ya_q.push_back(int'(y_addr)); yd_q.push_back(int'(y_wdata)); yc_q.push_back(cyc); end
    if (core_xw_val) nval++;
    if (core_start) nstart++;
    if (core_start && core_xw_last) nboth++;
    if (core_xw_val && int'(core_act_sel) != exp_act) act_bad++;
    if (done) begin done_seen = 1'b1; done_cyc = cyc; done_err = err; ndone++; end
  end

  logic [52:0] outs;
  assign outs = {busy, done, err, x_addr, w_addr, b_addr, mem_re, core_start, core_xw_val,
                 core_xw_last, core_act_sel, y_we, y_addr, y_wdata};

  int checks = 0, errors = 0, s_cyc;

  task automatic chk(string tag, longint obs, longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    iw_q.delete(); ix_q.delete(); ib_q.delete(); ya_q.delete(); yd_q.delete(); yc_q.delete();
    nval = 0; nstart = 0; nboth = 0; ndone = 0; done_cyc = -1; act_bad = 0;
    done_seen = 1'b0; done_err = 1'b0;
  endtask

  task automatic fill_rand();
    foreach (x_mem[k]) x_mem[k] = 16'($urandom);
    foreach (w_mem[k]) w_mem[k] = 16'($urandom);
    foreach (b_mem[k]) b_mem[k] = 16'($urandom);
  endtask

  task automatic go(int nin, int nout, int act);
    clear_mon();
    exp_act = act;
    cfg_n_in = IW'(nin); cfg_n_out = OW'(nout); cfg_act_sel = 2'(act);
    start = 1'b1; s_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(int budget);
    for (int k = 0; k < budget && !done_seen; k++) tick();
    chk("done within budget", done_seen, 1);
  endtask

  function automatic logic [15:0] ref_y(int j, int nin, int act);
    longint s;
    s = longint'($signed(b_mem[j]));
    for (int i = 0; i < nin; i++)
      s += longint'($signed(x_mem[i])) * longint'($signed(w_mem[j*nin+i]));
    if (act == 1 && s < 0) return 16'h0;
    return s[15:0];
  endfunction

  task automatic check_layer(int nin, int nout, int act, int s);
    int bad = 0, ny;
    chk("done count", ndone, 1);
    chk("done cycle", done_cyc - s, 2 + nout*(nin+2));
    chk("err on good cfg", done_err, 0);
    chk("busy after done", busy, 0);
    chk("issue count", iw_q.size(), nin*nout);
    for (int k = 0; k < iw_q.size(); k++)
      if (iw_q[k] != k || ix_q[k] != k % nin || ib_q[k] != k / nin) bad++;
    chk("issue addresses", bad, 0);
    chk("xw_val beats", nval, nin*nout);
    chk("core_start count", nstart, nout);
    chk("start+last coincide", nboth, (nin == 1) ? nout : 0);
    chk("act_sel stable", act_bad, 0);
    chk("y write count", ya_q.size(), nout);
    ny = (ya_q.size() < nout) ? ya_q.size() : nout;
    for (int j = 0; j < ny; j++) begin
      chk("y addr", ya_q[j], j);
      chk("y data", yd_q[j], int'(ref_y(j, nin, act)));
      chk("y cycle", yc_q[j] - s, 1 + (j+1)*(nin+2));
    end
  endtask

  task automatic check_bad(int nin, int nout);
    go(nin, nout, 0);
    wait_done(20);
    chk("bad cfg done cycle", done_cyc - s_cyc, 2);
    chk("bad cfg err", done_err, 1);
    chk("bad cfg mem_re", iw_q.size(), 0);
    chk("bad cfg xw_val", nval, 0);
    chk("bad cfg y_we", ya_q.size(), 0);
  endtask

  initial begin
    int nin, nout, act, t;
    clear_mon();
    exp_act = 0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset outputs", outs, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle outputs", outs, 0);

    // Test 1/2: directed small layer, linear then ReLU
    for (int a = 0; a < 2; a++) begin
      x_mem[0] = 16'd1; x_mem[1] = 16'd2; x_mem[2] = 16'd3;
      for (int k = 0; k < 3; k++) begin w_mem[k] = 16'd1; w_mem[k+3] = 16'hFFFF; end
      b_mem[0] = 16'd10; b_mem[1] = 16'd0;
      go(3, 2, a);
      wait_done(100);
      check_layer(3, 2, a, s_cyc);
      if (yd_q.size() == 2) begin
        chk("t1 y0", yd_q[0], 16);
        chk("t1 y1", yd_q[1], (a == 0) ? 32'hFFFA : 0);
      end
    end

    // Test 3: single-input neurons
    fill_rand();
    go(1, 3, 0);
    wait_done(100);
    check_layer(1, 3, 0, s_cyc);

    // Test 4: illegal configurations
    check_bad(0, 2);
    check_bad(3, MAX_OUT + 1);
    check_bad(MAX_IN + 1, 1);
    check_bad(4, 0);

    // Randomized layers
    for (int r = 0; r < 8; r++) begin
      fill_rand();
      nin = $urandom_range(1, 12); nout = $urandom_range(1, 8); act = $urandom_range(0, 1);
      go(nin, nout, act);
      wait_done(nout*(nin+2) + 20);
      check_layer(nin, nout, act, s_cyc);
    end
    fill_rand();
    act = $urandom_range(0, 1);
    go(MAX_IN, MAX_OUT, act);
    wait_done(MAX_OUT*(MAX_IN+2) + 20);
    check_layer(MAX_IN, MAX_OUT, act, s_cyc);

    // Test 5a: start and cfg change while busy are ignored
    fill_rand();
    go(3, 2, 0);
    t = s_cyc + 4;
    while (cyc < t) tick();
    start = 1'b1; cfg_n_in = IW'(5); cfg_n_out = OW'(1); cfg_act_sel = 2'd1;
    tick();
    start = 1'b0;
    wait_done(100);
    check_layer(3, 2, 0, s_cyc);

    // Test 5b: abort on the cycle neuron 1's result arrives
    fill_rand();
    go(4, 3, 1);
    t = s_cyc + 1 + 2*6;
    while (cyc < t) tick();
    abort = 1'b1;
    @(negedge clk);
    chk("core_done in flight", core_done, 1);
    chk("y_we suppressed on abort", y_we, 0);
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("busy after abort", busy, 0);
    repeat (30) tick();
    chk("no done after abort", ndone, 0);
    chk("writes before abort", ya_q.size(), 1);
    if (yd_q.size() >= 1) chk("y0 before abort", yd_q[0], int'(ref_y(0, 4, 1)));
    go(4, 3, 1);
    wait_done(100);
    check_layer(4, 3, 1, s_cyc);

    // Test 6: reset mid-ISSUE
    fill_rand();
    go(5, 2, 1);
    t = s_cyc + 3;
    while (cyc < t) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("outputs after mid-layer reset", outs, 0);
    tick();
    chk("no done after reset", ndone, 0);
    go(5, 2, 1);
    wait_done(100);
    check_layer(5, 2, 1, s_cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
